// File: rtl/io_port_unit_pkg.sv
// io_port_unit_pkg: opcodes, default width and outbound state encoding shared with control
package io_port_unit_pkg;
  localparam logic [3:0] OP_WRI = 4'd12;
  localparam logic [3:0] OP_REA = 4'd13;
  localparam int IO_WIDTH = 16;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;
endpackage

// File: rtl/io_in_fifo.sv
// io_in_fifo: inbound word FIFO with naturally wrapping pointers and an extra count bit
module io_in_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: wri/rea port with one-entry outbound register, inbound FIFO and PC stall
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int IN_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_wr,
  input  logic                        io_rd,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic [$clog2(IN_DEPTH):0]   in_count
);
  out_state_t state, nstate;
  logic wr, load, pop, empty, full;
  logic [WIDTH-1:0] head;
  // a read always wins over a (illegal) simultaneous write
  assign wr = io_wr && !io_rd;
  always_comb begin
    load = wr && (state == OUT_EMPTY || out_ready);
    nstate = wr ? OUT_FULL : (out_ready ? OUT_EMPTY : state);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= OUT_EMPTY;
      out_data <= '0;
    end else begin
      state <= nstate;
      if (load) out_data <= wdata;
    end
  assign out_valid = state == OUT_FULL;
  assign pop = io_rd && !empty;
  assign rdata = pop ? head : '0;
  assign stall = (io_rd && empty) || (wr && out_valid && !out_ready);
  assign in_ready = !full;
  io_in_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (in_data),
    .head  (head),
    .count (in_count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed plan plus random traffic against a queue-based reference model
module tb_io_port_unit;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic io_wr = 0, io_rd = 0, out_ready = 0, in_valid = 0;
  logic [15:0] wdata = 0, in_data = 0, rdata, out_data;
  logic stall, out_valid, in_ready;
  logic [2:0] in_count;
  int total = 0, bad = 0;
  logic [15:0] q[$];
  bit ov = 0;
  logic [15:0] od = 0;

  io_port_unit #(.WIDTH(16), .IN_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .wdata(wdata),
    .rdata(rdata), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_count(in_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ov = 0;
    od = 0;
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [15:0] wd,
                     input logic ordy, input logic ival, input logic [15:0] idat);
    bit can_push, wrote;
    io_wr = wr; io_rd = rd; wdata = wd; out_ready = ordy; in_valid = ival; in_data = idat;
    #2;
    chk("stall", 32'(stall), rd ? 32'(q.size() == 0) : 32'(wr && ov && !ordy));
    chk("rdata", 32'(rdata), (rd && q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_data", 32'(out_data), 32'(od));
    chk("in_count", 32'(in_count), 32'(q.size()));
    can_push = ival && q.size() != DEPTH;
    wrote = wr && !rd;
    @(posedge clk);
    #1;
    if (ov && ordy) ov = 0;
    if (wrote && !ov) begin ov = 1; od = wd; end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (can_push) q.push_back(idat);
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_in_count", 32'(in_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    // outbound backpressure
    cyc(1, 0, 16'h00A5, 0, 0, 0);
    chk("bp_hold0", 32'(out_data), 32'h00A5);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    io_wr = 1; wdata = 16'h1234; out_ready = 0; #1;
    chk("bp_stall", 32'(stall), 1);
    cyc(1, 0, 16'h1234, 0, 0, 0);
    chk("bp_hold1", 32'(out_data), 32'h00A5);
    cyc(1, 0, 16'h1234, 1, 0, 0);
    chk("bp_new", 32'(out_data), 32'h1234);
    // back-to-back writes
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 16'(i), 1, 0, 0);
      chk("b2b_data", 32'(out_data), 32'(i));
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("b2b_drained", 32'(out_valid), 0);
    // read from empty, word arrives this cycle
    cyc(0, 1, 0, 0, 1, 16'hBEEF);
    io_rd = 1; in_valid = 0; #1;
    chk("rd_retry_data", 32'(rdata), 32'hBEEF);
    chk("rd_retry_stall", 32'(stall), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rd_empty_again", 32'(in_count), 0);
    // fill, overflow attempt, interleave across wrap
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 1, 16'(i));
    chk("full_ready", 32'(in_ready), 0);
    cyc(0, 0, 0, 0, 1, 16'h0005);
    chk("full_count", 32'(in_count), 4);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 1, 16'h0010 + 16'(i));
    for (int i = 0; i < 8 && q.size() > 0; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("wrap_empty", 32'(in_count), 0);
    // simultaneous push/pop at two entries
    cyc(0, 0, 0, 0, 1, 16'hAAAA);
    cyc(0, 0, 0, 0, 1, 16'hBBBB);
    io_rd = 1; in_valid = 1; in_data = 16'hCCCC; #1;
    chk("pp_rdata", 32'(rdata), 32'hAAAA);
    cyc(0, 1, 0, 0, 1, 16'hCCCC);
    chk("pp_count", 32'(in_count), 2);
    // asynchronous reset mid-transfer
    cyc(1, 0, 16'h5555, 0, 0, 0);
    chk("mid_valid_pre", 32'(out_valid), 1);
    io_wr = 0; io_rd = 0; in_valid = 0; out_ready = 0;
    #2 reset = 1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in_count", 32'(in_count), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_out_data", 32'(out_data), 0);
    reset = 0;
    model_reset();
    // random traffic
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Services the processor's wri (op 12) and rea (op 13) instructions.
- Sits between the datapath/control (write strobe, read strobe, register data) and an external peripheral that uses valid/ready handshakes.
- Buffers inbound words in a small FIFO and outbound words in a one-entry holding register.
- Raises stall to freeze the PC when an I/O instruction cannot complete in the current cycle.

Parameters:
- WIDTH, 16: data word width for both directions.
- IN_DEPTH, 4: inbound FIFO depth. Must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_wr  input  1  wri executing this cycle; qualified by control MEMWRITE for op 12.
- io_rd  input  1  rea executing this cycle; qualified by control MEMREAD for op 13.
- wdata  input  WIDTH  register value to send out.
- rdata  output  WIDTH  word returned to the register-write path.
- stall  output  1  hold PC and pipeline; the instruction retries next cycle.
- out_valid  output  1  outbound word available.
- out_ready  input  1  peripheral accepts the outbound word.
- out_data  output  WIDTH  outbound word.
- in_valid  input  1  peripheral presents an inbound word.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  WIDTH  inbound word.
- in_count  output  clog2(IN_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, any time): out_valid=0, out_data=0, rdata=0, stall=0, in_count=0, FIFO pointers=0, in_ready=1 immediately. Any word in flight is discarded.
- Outbound FSM, states OUT_EMPTY and OUT_FULL. out_valid=1 exactly when in OUT_FULL.
  - OUT_EMPTY, io_wr=1: load wdata into out_data on the edge, go to OUT_FULL, stall=0.
  - OUT_FULL, out_ready=1, io_wr=0: go to OUT_EMPTY.
  - OUT_FULL, out_ready=1, io_wr=1: reload wdata and stay in OUT_FULL. Back-to-back writes run with no stall.
  - OUT_FULL, out_ready=0, io_wr=1: stall=1 combinationally; register unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
- Inbound FIFO:
  - in_ready = (in_count != IN_DEPTH).
  - Push on the edge when in_valid && in_ready.
  - Read and write pointers are clog2(IN_DEPTH) bits and wrap naturally. in_count has one extra bit so that full is distinguishable from empty.
- Read:
  - io_rd=1 with in_count>0: rdata = FIFO head combinationally (zero-latency). Pop on the edge; stall=0.
  - io_rd=1 with in_count=0: stall=1 and rdata=0. There is no same-cycle bypass from in_data; a word pushed this cycle is returned on the retry next cycle.
  - io_rd=0: rdata=0.
- Simultaneous push and pop: legal whenever in_ready=1. in_count is unchanged and the pointers both advance.
- When full: in_ready=0, so no push happens, even if a pop occurs the same cycle. This avoids a combinational ready path.
- io_wr and io_rd together: illegal from control. The block serves io_rd, ignores io_wr, and stall follows the read rules only.
- stall is purely combinational from the inputs and state. The block never stalls while io_wr=0 and io_rd=0.

Decomposition:
- Shared package holds:
  - opcode constants OP_WRI=4'd12 and OP_REA=4'd13, shared with control_component;
  - localparam WIDTH default;
  - the outbound state encoding, OUT_EMPTY=1'b0 and OUT_FULL=1'b1.
- One sub-module, io_in_fifo: parameterised WIDTH/IN_DEPTH FIFO with push, pop, head, count, full and empty.
- The outbound FSM and stall logic live in the top.

Test Plan:
- Reset mid-transfer: out_valid=1 and in_count=2, then assert reset asynchronously between edges. Required: out_valid=0, in_count=0 and in_ready=1 before the next edge.
- Outbound backpressure: io_wr with wdata=16'h00A5, out_ready=0 for 3 cycles; then a second io_wr with 16'h1234. Required: stall=1 during the second io_wr while out_ready=0. out_data holds 16'h00A5 until out_ready=1; the next cycle out_data=16'h1234.
- Back-to-back writes: out_ready held 1, io_wr on 4 consecutive cycles with 1, 2, 3, 4. Required: stall=0 throughout, and out_data sequence 1, 2, 3, 4, one per cycle.
- Read from empty FIFO: io_rd with in_count=0, then push in_data=16'hBEEF. Required: stall=1 and rdata=0 in cycle 0; in cycle 1 stall=0 and rdata=16'hBEEF; in_count returns to 0.
- FIFO fill and wrap: push 16'h0001 through 16'h0004, then attempt a push of 16'h0005. Required: in_ready=0 and the fifth word is not taken. Then 6 interleaved push/pop cycles; reads return words in FIFO order across pointer wrap.
- Simultaneous push and pop at in_count=2. Required: in_count stays 2 and rdata equals the oldest word.
